mul_hilo_ctrl: RTL and testbench

- Multi-cycle multiply/accumulate controller that owns the architectural HI/LO registers.
- Sequences an iterative shift-add multiplier for MULT/MULTU/MADD/MADDU/MSUB/MSUBU, and services MTHI/MTLO/MFHI/MFLO.
- Sits beside the ALU in the execute stage and stalls the pipeline while HI/LO are not yet valid.

---
 rtl/mul_pkg.sv | 43 ++++
 rtl/mul_iter_core.sv | 38 +++
 rtl/mul_hilo_ctrl.sv | 121 ++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the HI/LO multiply/accumulate controller.
package mul_pkg;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    MADD  = 4'd3,
    MADDU = 4'd4,
    MSUB  = 4'd5,
    MSUBU = 4'd6,
    MTHI  = 4'd7,
    MTLO  = 4'd8,
    MFHI  = 4'd9,
    MFLO  = 4'd10
  } mul_op_t;

  typedef enum logic [1:0] {IDLE, RUN, WB} mul_state_t;

  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_mode_t;

  function automatic int niter(input int iter_bits);
    return 32 / iter_bits;
  endfunction

  function automatic logic is_mul(input mul_op_t op);
    return (op == MULT) || (op == MULTU) || (op == MADD) ||
           (op == MADDU) || (op == MSUB) || (op == MSUBU);
  endfunction

  function automatic logic is_signed_op(input mul_op_t op);
    return (op == MULT) || (op == MADD) || (op == MSUB);
  endfunction

  function automatic acc_mode_t acc_mode(input mul_op_t op);
    case (op)
      MADD, MADDU: return ACC_ADD;
      MSUB, MSUBU: return ACC_SUB;
      default:     return ACC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mul_iter_core.sv
// Shift-add multiplier datapath: retires ITER_BITS multiplier bits per step
// into a 64-bit unsigned partial product.
module mul_iter_core
  import mul_pkg::*;
#(
  parameter int ITER_BITS = 2
) (
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] a_val,
  input  logic [31:0] b_val,
  output logic [63:0] partial
);

  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] addend;

  // The multiplicand pre-shifts left each step, so the digit product is
  // already aligned; the true product never exceeds 64 bits.
  always_comb begin
    addend = mcand * {{(64-ITER_BITS){1'b0}}, mplier[ITER_BITS-1:0]};
  end

  always_ff @(posedge clk) begin
    if (load) begin
      mcand   <= {32'd0, a_val};
      mplier  <= b_val;
      partial <= '0;
    end else if (step) begin
      partial <= partial + addend;
      mcand   <= mcand << ITER_BITS;
      mplier  <= mplier >> ITER_BITS;
    end
  end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// HI/LO owner: sequences the iterative multiplier, applies sign and
// accumulate, and services the HI/LO move instructions.
module mul_hilo_ctrl
  import mul_pkg::*;
#(
  parameter int ITER_BITS = 2
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Stall,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Z,
  output logic        N
);

  localparam int NITER = niter(ITER_BITS);
  localparam int CNT_W = $clog2(NITER);

  mul_state_t       state, state_nxt;
  mul_op_t          op;
  logic             accept, load;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  acc_mode_t        acc;
  logic [31:0]      a_abs, b_abs;
  logic [63:0]      partial, prod, hilo_nxt;

  assign op     = mul_op_t'(Op);
  assign Busy   = (state != IDLE);
  assign Stall  = Start & Busy & (op != NOP);
  assign accept = Start & ~Stall & ~Flush & (state == IDLE);
  assign load   = accept & is_mul(op);

  assign a_abs = (is_signed_op(op) && A[31]) ? -A : A;
  assign b_abs = (is_signed_op(op) && B[31]) ? -B : B;

  mul_iter_core #(
    .ITER_BITS (ITER_BITS)
  ) u_core (
    .clk     (Clock),
    .load    (load),
    .step    (state == RUN),
    .a_val   (a_abs),
    .b_val   (b_abs),
    .partial (partial)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = RUN;
      RUN:     if (Flush) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prod = neg ? -partial : partial;
    case (acc)
      ACC_ADD: hilo_nxt = {HI, LO} + prod;
      ACC_SUB: hilo_nxt = {HI, LO} - prod;
      default: hilo_nxt = prod;
    endcase
  end

  always_comb begin
    Result = '0;
    if (Start && state == IDLE) begin
      if (op == MFHI) Result = HI;
      else if (op == MFLO) Result = LO;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      HI   <= '0;
      LO   <= '0;
      Z    <= 1'b0;
      N    <= 1'b0;
      Done <= 1'b0;
      cnt  <= '0;
      neg  <= 1'b0;
      acc  <= ACC_NONE;
    end else begin
      Done <= 1'b0;
      if (load) begin
        cnt <= CNT_W'(NITER - 1);
        neg <= is_signed_op(op) & (A[31] ^ B[31]);
        acc <= acc_mode(op);
      end else if (state == RUN) begin
        cnt <= cnt - 1'b1;
      end
      if (accept && op == MTHI) HI <= A;
      if (accept && op == MTLO) LO <= A;
      // Flush wins over the writeback.
      if (state == WB && !Flush) begin
        {HI, LO} <= hilo_nxt;
        Z        <= (hilo_nxt == 64'd0);
        N        <= hilo_nxt[63];
        Done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Scoreboard bench for mul_hilo_ctrl: stimulus queues expected HI/LO and
// read results, a negedge monitor pops them when Done or a read appears.
module tb_mul_hilo_ctrl;
  import mul_pkg::*;

  localparam int NITER = 16;

  logic        Clock, nReset, Start, Flush;
  logic [3:0]  Op;
  logic [31:0] A, B;
  logic        Stall, Busy, Done, Z, N;
  logic [31:0] Result, HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z;
    logic        n;
  } mul_exp_t;

  mul_exp_t    mul_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          failures = 0;

  mul_hilo_ctrl #(.ITER_BITS(2)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .Flush  (Flush),
    .Stall  (Stall),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .HI     (HI),
    .LO     (LO),
    .Z      (Z),
    .N      (N)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares every Done pulse and every accepted read.
  initial begin
    mul_exp_t e;
    logic [31:0] r;
    forever begin
      @(negedge Clock);
      if (nReset && Done) begin
        if (mul_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=Done required=no_Done HI=0x%0h LO=0x%0h", HI, LO);
        end else begin
          e = mul_q.pop_front();
          chk("done_hi", 64'(HI), 64'(e.hi));
          chk("done_lo", 64'(LO), 64'(e.lo));
          chk("done_z", 64'(Z), 64'(e.z));
          chk("done_n", 64'(N), 64'(e.n));
        end
      end
      if (nReset && Start && !Stall && !Flush && (Op == MFHI || Op == MFLO)) begin
        if (rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read actual=0x%0h required=no_read", Result);
        end else begin
          r = rd_q.pop_front();
          chk("read_result", 64'(Result), 64'(r));
        end
      end
    end
  end

  task automatic align();
    @(posedge Clock);
    #1;
  endtask

  // Caller is just past a posedge. Holds the command until not stalled;
  // returns just past the acceptance edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    stalls = 0;
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    while (1) begin
      @(negedge Clock);
      if (!Stall) break;
      stalls++;
      if (stalls > 40) begin
        checks++;
        failures++;
        $display("FAIL stall_timeout actual=%0d required<=40", stalls);
        break;
      end
    end
    align();
    Start = 1'b0;
    Op = NOP;
  endtask

  task automatic wait_done(output int lat);
    int k = 0;
    lat = -1;
    while (k < 60) begin
      @(negedge Clock);
      k++;
      if (Done) begin
        lat = k - 1;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=Done");
    end
  endtask

  task automatic do_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic ez, input logic en);
    mul_exp_t e;
    int st, lat;
    e.hi = ehi;
    e.lo = elo;
    e.z = ez;
    e.n = en;
    mul_q.push_back(e);
    align();
    issue(op, a, b, st);
    wait_done(lat);
    chk("latency", 64'(lat), 64'(NITER + 1));
  endtask

  task automatic do_move(input logic [3:0] op, input logic [31:0] a);
    int st;
    align();
    issue(op, a, 32'd0, st);
  endtask

  task automatic do_read(input logic [3:0] op, input logic [31:0] exp_val);
    int st;
    rd_q.push_back(exp_val);
    align();
    issue(op, 32'd0, 32'd0, st);
  endtask

  initial begin
    int st;
    nReset = 1'b1;
    Start = 1'b0;
    Flush = 1'b0;
    Op = NOP;
    A = '0;
    B = '0;
    #1 nReset = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_z", 64'(Z), 64'd0);
    chk("rst_n", 64'(N), 64'd0);
    chk("rst_stall", 64'(Stall), 64'd0);
    chk("rst_result", 64'(Result), 64'd0);
    nReset = 1'b1;

    do_mul(MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
    do_mul(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);

    do_move(MTHI, 32'd0);
    do_move(MTLO, 32'd5);
    do_read(MFHI, 32'd0);
    do_read(MFLO, 32'd5);
    do_mul(MADD, 32'd3, 32'd4, 32'd0, 32'h11, 1'b0, 1'b0);
    do_mul(MSUBU, 32'd1, 32'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);

    // Dependent read right behind a multiply.
    mul_q.push_back('{hi: 32'd0, lo: 32'd6, z: 1'b0, n: 1'b0});
    rd_q.push_back(32'd6);
    align();
    issue(MULT, 32'd2, 32'd3, st);
    issue(MFLO, 32'd0, 32'd0, st);
    chk("dep_stall_cycles", 64'(st), 64'(NITER + 1));

    // 6 - (-2*3) = 12; then 12 + 0xFFFFFFFF*2 = 0x2_0000000A
    do_mul(MSUB, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'hC, 1'b0, 1'b0);
    do_mul(MADDU, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'hA, 1'b0, 1'b0);

    // Flush during RUN cycle 8.
    do_move(MTLO, 32'd9);
    align();
    issue(MULT, 32'd5, 32'd5, st);
    repeat (7) align();
    Flush = 1'b1;
    align();
    Flush = 1'b0;
    chk("flush_run_busy", 64'(Busy), 64'd0);
    repeat (20) align();
    chk("flush_run_lo", 64'(LO), 64'd9);
    chk("flush_run_hi", 64'(HI), 64'd2);
    do_mul(MULT, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Flush in WB beats the writeback.
    align();
    issue(MULT, 32'd2, 32'd2, st);
    repeat (16) align();
    Flush = 1'b1;
    align();
    Flush = 1'b0;
    chk("flush_wb_busy", 64'(Busy), 64'd0);
    repeat (5) align();
    chk("flush_wb_lo", 64'(LO), 64'd0);
    chk("flush_wb_z", 64'(Z), 64'd1);

    // Flush with Start in IDLE drops the command.
    align();
    Start = 1'b1;
    Op = MTHI;
    A = 32'hDEAD;
    Flush = 1'b1;
    align();
    Start = 1'b0;
    Op = NOP;
    Flush = 1'b0;
    align();
    chk("flush_idle_hi", 64'(HI), 64'd0);

    // Asynchronous reset in the middle of RUN.
    do_move(MTHI, 32'h1234);
    do_move(MTLO, 32'h55);
    align();
    issue(MULT, 32'd3, 32'd3, st);
    repeat (4) align();
    nReset = 1'b0;
    #1;
    chk("arst_hi", 64'(HI), 64'd0);
    chk("arst_lo", 64'(LO), 64'd0);
    chk("arst_busy", 64'(Busy), 64'd0);
    align();
    nReset = 1'b1;
    rd_q.push_back(32'd0);
    align();
    issue(MFHI, 32'd0, 32'd0, st);
    chk("post_rst_stall", 64'(st), 64'd0);

    repeat (25) align();
    chk("mul_q_empty", 64'(mul_q.size()), 64'd0);
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
